fft_band_levels: RTL and testbench
==================================

# fft_band_levels

Reduces the per-bin FFT magnitude stream (24-bit magnitude, 7-bit bin index, one valid strobe per bin) into eight per-band levels for the LED driver. It sits directly downstream of the FFT magnitude stage and upstream of the LED pattern logic. Once per FFT frame it averages the bins in each band and applies optional peak-hold/decay smoothing. It then streams the eight band levels out over a valid/ready handshake.

## Interface
- DECAY_SHIFT, 3: decay rate; each frame a level may fall by at most level >> DECAY_SHIFT.
- clk_100mhz  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- freq_mag  input  24  bin magnitude from the magnitude stage.
- freq_index  input  7  bin number (0..127) qualifying freq_mag.
- valid_in  input  1  freq_mag/freq_index valid this cycle. There is no backpressure; a beat may arrive every cycle.
- band_level  output  24  smoothed level of band band_id.
- band_id  output  3  band number 0..7.
- band_valid  output  1  band_level/band_id valid.
- band_ready  input  1  consumer accepts the beat when band_valid && band_ready.
- band_last  output  1  high with band_id == 7.
- frame_overrun  output  1  sticky; set when a frame commits while the output stream is still busy.

## Operation
- Only bins 1..63 are used. Bin 0 (DC) and bins 64..127 (mirror half) are ignored.
- Band b (0..7) covers bins 8b..8b+7, so band 0 holds bins 1..7.
- Accumulators: eight 27-bit sums. A valid beat with a used bin adds freq_mag to its band's sum.
- Commit trigger: a valid beat with freq_index == 63. On the following edge (the commit edge):
  - avg_b = acc_b >> 3. Band 0 is also shifted by 3 (divide by 8, not 7).
  - level_b is updated from avg_b (see Configuration).
  - All accumulators clear to 0.
  - If the stream FSM is IDLE, it enters STREAM with band_id = 0.
  - If the stream FSM is already in STREAM, frame_overrun is set. The stream continues from its current band_id and presents the newly updated levels for the remaining bands.
- Stream FSM states:
  - IDLE: band_valid = 0.
  - STREAM: band_valid = 1 and band_level = level[band_id].
  - On each accepted beat, band_id increments. Acceptance at band_id == 7 returns the FSM to IDLE with band_id = 0.
  - While band_valid is high and band_ready is low, band_id and band_level are held. Exception: band_level may change on a commit edge (overrun case only).
- Arithmetic: level registers are 24 bits and avg_b always fits in 24 bits. Decay subtraction never underflows because level >> DECAY_SHIFT <= level.
- Reset values:
  - All accumulators and levels: 0.
  - FSM: IDLE.
  - band_valid = 0, band_id = 0, band_last = 0, band_level = 0.
  - frame_overrun = 0. Only rst clears it.
- Reset mid-frame or mid-stream: everything returns to reset values on the next edge. The partial frame is discarded and no beat is emitted.

## Timing
- Accumulator update: 1 cycle after each valid beat.
- Commit: the valid beat with index 63 is sampled at edge N. Levels update and band_valid rises at edge N+1, so band 0 is visible in cycle N+1.
- With band_ready held high, the eight beats occupy cycles N+1..N+8, and band_last is high in cycle N+8.
- A beat with index 64 arriving at edge N+1 is ignored, so it does not conflict with the accumulator clear.
- Outputs are fully registered; there is no combinational path from band_ready to band_valid.

## Configuration
- BAND_DECAY_EN defined: level_b <= max(avg_b, level_b − (level_b >> DECAY_SHIFT)). Levels attack instantly and decay geometrically.
- BAND_DECAY_EN undefined: level_b <= avg_b every frame, with no smoothing. DECAY_SHIFT is unused.

## Test plan
- Flat spectrum: bins 0..127 all 0x000100, back-to-back, band_ready=1 -> beats band 0 = 0x0000E0, bands 1..7 = 0x000100; band_last high on beat 8 only; band_valid rises 1 cycle after the index-63 beat.
- Decay (BAND_DECAY_EN defined, DECAY_SHIFT=3): frame 1 has bins 24..31 = 0x008000, all others 0 -> band 3 = 0x008000. Frames 2 and 3 all zero -> band 3 = 0x007000, then 0x006200. Without the macro -> 0x008000, then 0, then 0.
- Backpressure: band_ready toggles 1/0 each cycle -> each band emitted exactly once, in order 0..7, with values stable while stalled; frame_overrun stays 0 if the stream completes before the next index 63.
- Overrun: band_ready=0 across two full frames -> frame_overrun = 1 after the second commit; band 0 beat shows the second frame's level; the flag persists until rst.
- Ignored bins: only bin 0 and bin 100 = 0xFFFFFF, others 0 -> all eight levels 0.
- Mid-stream reset: assert rst for 1 cycle while streaming band 4 -> next cycle band_valid=0, frame_overrun=0; the next full frame streams from band 0 with unsmoothed values (levels were 0).

Source files
------------

// File: rtl/fft_band_levels.sv
// Reduces the FFT magnitude stream (bins 1..63) to eight per-band levels, streamed once per frame.
// Optional peak-hold/decay smoothing is enabled by defining BAND_DECAY_EN.
module fft_band_levels #(
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic [23:0] freq_mag,
  input  logic [6:0]  freq_index,
  input  logic        valid_in,
  output logic [23:0] band_level,
  output logic [2:0]  band_id,
  output logic        band_valid,
  input  logic        band_ready,
  output logic        band_last,
  output logic        frame_overrun
);

`ifdef BAND_DECAY_EN
  localparam bit DecayEn = 1'b1;
`else
  localparam bit DecayEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e      state_q, state_d;
  logic [26:0] acc_q [8];
  logic [26:0] acc_d [8];
  logic [23:0] level_q [8];
  logic [23:0] level_d [8];
  logic [23:0] avg [8];
  logic [23:0] decayed [8];
  logic        commit_q, commit_d;
  logic [2:0]  band_id_q, band_id_d;
  logic [23:0] band_level_q, band_level_d;
  logic        band_last_q, band_last_d;
  logic        overrun_q, overrun_d;

  logic        bin_used;
  logic [2:0]  bin_band;
  logic        accept;

  // Bin 0 is DC and bins 64..127 mirror the lower half.
  assign bin_used = valid_in && (freq_index != 7'd0) && !freq_index[6];
  assign bin_band = freq_index[5:3];
  assign commit_d = valid_in && (freq_index == 7'd63);
  assign accept   = (state_q == StStream) && band_ready;

  // A used bin arriving on the commit edge starts the fresh frame rather than being lost.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      acc_d[b] = commit_q ? 27'd0 : acc_q[b];
      if (bin_used && (bin_band == 3'(b))) begin
        acc_d[b] = acc_d[b] + {3'b000, freq_mag};
      end
    end
  end

  // Band 0 has only seven used bins but is still divided by eight.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      avg[b]     = acc_q[b][26:3];
      decayed[b] = level_q[b] - (level_q[b] >> DECAY_SHIFT);
      level_d[b] = level_q[b];
      if (commit_q) begin
        level_d[b] = (DecayEn && (decayed[b] > avg[b])) ? decayed[b] : avg[b];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    band_id_d = band_id_q;
    overrun_d = overrun_q;
    case (state_q)
      StIdle: begin
        if (commit_q) begin
          state_d   = StStream;
          band_id_d = 3'd0;
        end
      end
      StStream: begin
        if (accept) begin
          if (band_id_q == 3'd7) begin
            state_d   = StIdle;
            band_id_d = 3'd0;
          end else begin
            band_id_d = band_id_q + 3'd1;
          end
        end
        // A commit while busy keeps streaming; if the last beat just went, start the new frame.
        if (commit_q) begin
          overrun_d = 1'b1;
          if (accept && (band_id_q == 3'd7)) begin
            state_d = StStream;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        band_id_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    band_level_d = 24'd0;
    band_last_d  = 1'b0;
    if (state_d == StStream) begin
      band_level_d = level_d[band_id_d];
      band_last_d  = (band_id_d == 3'd7);
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q      <= StIdle;
      commit_q     <= 1'b0;
      band_id_q    <= 3'd0;
      band_level_q <= 24'd0;
      band_last_q  <= 1'b0;
      overrun_q    <= 1'b0;
      for (int b = 0; b < 8; b++) begin
        acc_q[b]   <= 27'd0;
        level_q[b] <= 24'd0;
      end
    end else begin
      state_q      <= state_d;
      commit_q     <= commit_d;
      band_id_q    <= band_id_d;
      band_level_q <= band_level_d;
      band_last_q  <= band_last_d;
      overrun_q    <= overrun_d;
      for (int b = 0; b < 8; b++) begin
        acc_q[b]   <= acc_d[b];
        level_q[b] <= level_d[b];
      end
    end
  end

  assign band_valid    = (state_q == StStream);
  assign band_id       = band_id_q;
  assign band_level    = band_level_q;
  assign band_last     = band_last_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_fft_band_levels.sv
// Self-checking bench for fft_band_levels: directed scenarios plus randomized frames
// checked against a per-frame band-average model.
module tb_fft_band_levels;

  localparam int DS = 3;
`ifdef BAND_DECAY_EN
  localparam bit DecayEn = 1'b1;
`else
  localparam bit DecayEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] freq_mag = 24'd0;
  logic [6:0]  freq_index = 7'd0;
  logic        valid_in = 1'b0;
  logic        band_ready = 1'b0;
  logic [23:0] band_level;
  logic [2:0]  band_id;
  logic        band_valid;
  logic        band_last;
  logic        frame_overrun;

  always #5 clk = ~clk;

  fft_band_levels #(.DECAY_SHIFT(DS)) dut (
    .clk_100mhz   (clk),
    .rst          (rst),
    .freq_mag     (freq_mag),
    .freq_index   (freq_index),
    .valid_in     (valid_in),
    .band_level   (band_level),
    .band_id      (band_id),
    .band_valid   (band_valid),
    .band_ready   (band_ready),
    .band_last    (band_last),
    .frame_overrun(frame_overrun)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] frame_mag [128];
  logic [23:0] model_level [8];
  logic [23:0] pend_level [8];
  logic [23:0] last_seen [8];
  int          exp_id = 0;
  int          beat_cnt = 0;
  int          gen = 0;
  int          ready_mode = 0;
  logic        ready_hold = 1'b0;
  event        ev63;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] next_level(input logic [23:0] old, input logic [23:0] avg);
    logic [23:0] dec;
    dec = old - (old >> DS);
    return (DecayEn && (dec > avg)) ? dec : avg;
  endfunction

  // Levels the frame in frame_mag will produce, from the band/bin rules directly.
  task automatic compute_pending();
    for (int b = 0; b < 8; b++) begin
      logic [26:0] sum;
      sum = 27'd0;
      for (int j = 0; j < 8; j++) begin
        if (8 * b + j >= 1) sum += {3'b000, frame_mag[8 * b + j]};
      end
      pend_level[b] = next_level(model_level[b], sum[26:3]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: band_ready = ready_hold;
      1: band_ready = ~band_ready;
      default: band_ready = ($urandom_range(99) < 60);
    endcase
  end

  // Commit lands on the second edge after bin 63 is presented.
  always @(ev63) begin
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) model_level[b] = pend_level[b];
    gen++;
  end

  logic        prev_stall = 1'b0;
  logic [2:0]  prev_id;
  logic [23:0] prev_level;
  int          prev_gen;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", band_valid, 1);
        check("stall_id", band_id, prev_id);
        if (gen == prev_gen) check("stall_level", band_level, prev_level);
      end
      if (band_valid && band_ready) begin
        check("beat_id", band_id, exp_id);
        check("beat_level", band_level, model_level[exp_id]);
        check("beat_last", band_last, exp_id == 7);
        last_seen[band_id] = band_level;
        exp_id = (exp_id + 1) % 8;
        beat_cnt++;
      end else if (!band_valid) begin
        check("idle_last", band_last, 0);
      end
      prev_stall = band_valid && !band_ready;
      prev_id    = band_id;
      prev_level = band_level;
      prev_gen   = gen;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    for (int b = 0; b < 8; b++) model_level[b] = 24'd0;
    exp_id = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_frame(input bit shuffle, input int gap_pct);
    int order [128];
    int n;
    n = 0;
    for (int i = 0; i < 128; i++) begin
      if (!shuffle || i != 63) begin
        order[n] = i;
        n++;
      end
    end
    if (shuffle) begin
      for (int i = 126; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(i);
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      order[127] = 63;
    end
    for (int k = 0; k < 128; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        @(posedge clk);
        #1;
        valid_in = 1'b0;
      end
      @(posedge clk);
      #1;
      valid_in   = 1'b1;
      freq_index = 7'(order[k]);
      freq_mag   = frame_mag[order[k]];
      if (order[k] == 63) begin
        compute_pending();
        ->ev63;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (!band_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("stream_done", done, 1);
  endtask

  task automatic fill(input logic [23:0] v);
    for (int i = 0; i < 128; i++) frame_mag[i] = v;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    bit found;
    for (int b = 0; b < 8; b++) begin
      model_level[b] = 24'd0;
      last_seen[b]   = 24'hFFFFFF;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", band_valid, 0);
    check("rst_id", band_id, 0);
    check("rst_last", band_last, 0);
    check("rst_level", band_level, 0);
    check("rst_overrun", frame_overrun, 0);

    // Flat spectrum, always ready.
    ready_mode = 0;
    ready_hold = 1'b1;
    fill(24'h000100);
    b0 = beat_cnt;
    fork
      send_frame(1'b0, 0);
      begin
        @(ev63);
        @(negedge clk);
        @(negedge clk);
        check("flat_pre_valid", band_valid, 0);
        @(negedge clk);
        check("flat_rise_valid", band_valid, 1);
        check("flat_rise_id", band_id, 0);
        repeat (7) @(negedge clk);
        check("flat_last_n8", band_last, 1);
        check("flat_id_n8", band_id, 7);
        @(negedge clk);
        check("flat_after_valid", band_valid, 0);
      end
    join
    wait_idle();
    check("flat_beats", beat_cnt - b0, 8);
    check("flat_band0", last_seen[0], 24'h0000E0);
    for (int b = 1; b < 8; b++) check("flat_bandn", last_seen[b], 24'h000100);

    // Decay: one tone frame, then two silent frames.
    do_reset();
    fill(24'd0);
    for (int i = 24; i < 32; i++) frame_mag[i] = 24'h008000;
    send_frame(1'b0, 0);
    wait_idle();
    check("decay_f1", last_seen[3], 24'h008000);
    fill(24'd0);
    send_frame(1'b0, 0);
    wait_idle();
    check("decay_f2", last_seen[3], DecayEn ? 24'h007000 : 24'h0);
    send_frame(1'b0, 0);
    wait_idle();
    check("decay_f3", last_seen[3], DecayEn ? 24'h006200 : 24'h0);

    // Backpressure: ready toggles every cycle.
    ready_mode = 1;
    for (int i = 0; i < 128; i++) frame_mag[i] = 24'($urandom);
    b0 = beat_cnt;
    send_frame(1'b0, 0);
    wait_idle();
    check("bp_beats", beat_cnt - b0, 8);
    check("bp_overrun", frame_overrun, 0);

    // Ignored bins only.
    ready_mode = 0;
    ready_hold = 1'b1;
    do_reset();
    fill(24'd0);
    frame_mag[0]   = 24'hFFFFFF;
    frame_mag[100] = 24'hFFFFFF;
    send_frame(1'b0, 0);
    wait_idle();
    for (int b = 0; b < 8; b++) check("ignored_level", last_seen[b], 0);

    // Overrun: consumer stalled across two frames.
    ready_hold = 1'b0;
    for (int i = 0; i < 128; i++) frame_mag[i] = 24'($urandom);
    send_frame(1'b0, 0);
    check("ovr_after_a", frame_overrun, 0);
    for (int i = 0; i < 128; i++) frame_mag[i] = 24'($urandom);
    send_frame(1'b0, 0);
    check("ovr_after_b", frame_overrun, 1);
    b0 = beat_cnt;
    ready_hold = 1'b1;
    @(posedge clk);
    #1;
    wait_idle();
    check("ovr_beats", beat_cnt - b0, 8);
    check("ovr_band0_is_b", last_seen[0], model_level[0]);
    send_frame(1'b1, 10);
    wait_idle();
    check("ovr_sticky", frame_overrun, 1);

    // Reset while streaming band 4.
    ready_hold = 1'b0;
    for (int i = 0; i < 128; i++) frame_mag[i] = 24'($urandom);
    send_frame(1'b0, 0);
    ready_hold = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (band_valid && band_id == 3'd4) found = 1'b1;
    end
    check("mid_band4_seen", found, 1);
    ready_hold = 1'b0;
    do_reset();
    check("mid_rst_valid", band_valid, 0);
    check("mid_rst_overrun", frame_overrun, 0);
    check("mid_rst_id", band_id, 0);
    ready_hold = 1'b1;
    for (int i = 0; i < 128; i++) frame_mag[i] = 24'($urandom);
    b0 = beat_cnt;
    send_frame(1'b1, 0);
    wait_idle();
    check("mid_next_beats", beat_cnt - b0, 8);

    // Randomized frames with gaps and random ready.
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 128; i++) begin
        frame_mag[i] = ($urandom_range(3) == 0) ? 24'd0 : 24'($urandom >> $urandom_range(20));
      end
      b0 = beat_cnt;
      send_frame(1'b1, 20);
      wait_idle();
      check("rand_beats", beat_cnt - b0, 8);
    end
    check("rand_overrun", frame_overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
